// File: rtl/sif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sif_pkg
//  Description : Shared constants and helpers for the sif_fifo training
//                interface. Holds the default widths and depth, the level-width
//                constant, and the read-address scramble function.
//  Revision    : 1.0 - initial release
// ============================================================================
package sif_pkg;

  localparam int SIF_AW     = 16;
  localparam int SIF_DW     = 16;
  localparam int SIF_DEPTH  = 4;
  localparam int SIF_RD_LAT = 1;

  // Width of the occupancy counter for the default depth (0..DEPTH inclusive).
  localparam int SIF_LVL_W  = $clog2(SIF_DEPTH + 1);

  // Scramble operates on a wide container so any AW up to this width can use
  // it; only bits 8 and 7 change, everything else passes through.
  localparam int SIF_MAX_AW = 64;

  function automatic logic [SIF_MAX_AW-1:0] sif_scramble(input logic [SIF_MAX_AW-1:0] addr);
    logic [SIF_MAX_AW-1:0] s;
    s    = addr;
    s[8] = addr[8] ^ addr[4];
    s[7] = addr[7] ^ addr[5];
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sif_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sif_wr_fifo
//  Description : Synchronous FIFO with a registered head output and a
//                valid/ready pop. Total capacity DEPTH words, of which one
//                lives in the output register and DEPTH-1 in a circular buffer.
//  Ports       : clk, rst_b       - clock, async active-low reset
//                i_push, i_data   - push request and word
//                o_push_ready     - push accepted this cycle (level < DEPTH)
//                o_valid, o_data  - registered head word
//                i_ready          - downstream consumes the head this cycle
//                o_level          - words held, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sif_wr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_push_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [LW-1:0]    o_level
);

  localparam int c_buf_depth = DEPTH - 1;
  localparam int PW          = (c_buf_depth > 1) ? $clog2(c_buf_depth) : 1;
  localparam int CW          = $clog2(c_buf_depth + 1);
  localparam logic [PW-1:0] c_ptr_last = PW'(c_buf_depth - 1);

  logic [WIDTH-1:0] r_mem [c_buf_depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  logic [LW-1:0]    w_level;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_from_buf;
  logic             w_bypass;
  logic             w_buf_wr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == c_ptr_last) ? '0 : p + PW'(1);
  endfunction

  // Level is derived purely from registers, so push-ready has no path from
  // i_ready: a full FIFO refuses a push even if it pops in the same cycle.
  assign w_level      = LW'(r_cnt) + LW'(r_valid);
  assign o_push_ready = (w_level < LW'(DEPTH));
  assign o_level      = w_level;
  assign o_valid      = r_valid;
  assign o_data       = r_data;

  assign w_push     = i_push && o_push_ready;
  assign w_pop      = r_valid && i_ready;
  // Output register can take a new word when empty or being consumed.
  assign w_load     = !r_valid || w_pop;
  assign w_from_buf = w_load && (r_cnt != '0);
  // With nothing buffered, a push goes straight to the output register so
  // it appears the next cycle and streaming has no bubble.
  assign w_bypass   = w_load && (r_cnt == '0) && w_push;
  assign w_buf_wr   = w_push && !w_bypass;

  always_ff @(posedge clk) begin
    if (w_buf_wr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_buf_wr) begin
        r_wptr <= next_ptr(r_wptr);
      end
      if (w_from_buf) begin
        r_rptr <= next_ptr(r_rptr);
      end
      r_cnt <= r_cnt + CW'(w_buf_wr) - CW'(w_from_buf);
      if (w_load) begin
        r_valid <= w_from_buf || w_bypass;
        // Data is only replaced by a new word; otherwise the last head holds.
        if (w_from_buf) begin
          r_data <= r_mem[r_rptr];
        end else if (w_bypass) begin
          r_data <= i_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sif_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sif_fifo
//  Description : Training-interface bridge. Writes from the xa_* master are
//                buffered in a DEPTH-word FIFO and drained to the wa_* sink
//                with valid/ready. Reads return the scrambled address after
//                RD_LAT clocks with a valid strobe; reads never stall.
//  Ports       : clk, rst_b                  - clock, async active-low reset
//                xa_wr_s, xa_rd_s            - write / read requests
//                xa_addr, xa_data_wr         - shared address, write data
//                xa_wr_ready                 - write will be accepted
//                xa_data_rd, xa_rd_valid     - read return
//                wa_wr_s, wa_addr, wa_data_wr, wa_ready - downstream write
//                wr_overflow                 - sticky dropped-write flag
//                fifo_level                  - words held
//  Revision    : 1.0 - initial release
// ============================================================================
module sif_fifo
  import sif_pkg::*;
#(
  parameter int AW     = SIF_AW,
  parameter int DW     = SIF_DW,
  parameter int DEPTH  = SIF_DEPTH,
  parameter int RD_LAT = SIF_RD_LAT
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       xa_wr_s,
  input  logic                       xa_rd_s,
  input  logic [AW-1:0]              xa_addr,
  input  logic [DW-1:0]              xa_data_wr,
  output logic                       xa_wr_ready,
  output logic [DW-1:0]              xa_data_rd,
  output logic                       xa_rd_valid,
  output logic                       wa_wr_s,
  output logic [AW-1:0]              wa_addr,
  output logic [DW-1:0]              wa_data_wr,
  input  logic                       wa_ready,
  output logic                       wr_overflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  logic [AW+DW-1:0] w_head;
  logic             w_wr_ready;
  logic             r_overflow;
  logic [AW-1:0]    w_scr_addr;
  logic [DW-1:0]    w_rd_data;

  logic             r_rd_v [RD_LAT];
  logic [DW-1:0]    r_rd_d [RD_LAT];

  // ---------------------------------------------------------------- write path
  sif_wr_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_wr_fifo (
    .clk          (clk),
    .rst_b        (rst_b),
    .i_push       (xa_wr_s),
    .i_data       ({xa_addr, xa_data_wr}),
    .o_push_ready (w_wr_ready),
    .o_valid      (wa_wr_s),
    .o_data       (w_head),
    .i_ready      (wa_ready),
    .o_level      (fifo_level)
  );

  assign xa_wr_ready = w_wr_ready;
  assign wa_addr     = w_head[AW+DW-1:DW];
  assign wa_data_wr  = w_head[DW-1:0];
  assign wr_overflow = r_overflow;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_overflow <= 1'b0;
    end else if (xa_wr_s && !w_wr_ready) begin
      r_overflow <= 1'b1;
    end
  end

  // ----------------------------------------------------------------- read path
  // Scrambled address is resized to DW: zero-extended or truncated.
  assign w_scr_addr = AW'(sif_scramble(SIF_MAX_AW'(xa_addr)));
  assign w_rd_data  = DW'(w_scr_addr);

  // Data is zeroed on entry for idle slots so the output is 0 whenever the
  // strobe is low, without a gating mux at the end of the pipe.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rd_v[0] <= 1'b0;
      r_rd_d[0] <= '0;
    end else begin
      r_rd_v[0] <= xa_rd_s;
      r_rd_d[0] <= xa_rd_s ? w_rd_data : '0;
    end
  end

  generate
    for (genvar s = 1; s < RD_LAT; s++) begin : g_rd_pipe
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          r_rd_v[s] <= 1'b0;
          r_rd_d[s] <= '0;
        end else begin
          r_rd_v[s] <= r_rd_v[s-1];
          r_rd_d[s] <= r_rd_d[s-1];
        end
      end
    end
  endgenerate

  assign xa_rd_valid = r_rd_v[RD_LAT-1];
  assign xa_data_rd  = r_rd_d[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_sif_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sif_fifo
//  Description : Self-checking bench for sif_fifo. Two instances (RD_LAT=1
//                and RD_LAT=3) share stimulus; a queue-based model predicts
//                every output each cycle, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sif_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        xa_wr_s = 1'b0;
  logic        xa_rd_s = 1'b0;
  logic [15:0] xa_addr = '0;
  logic [15:0] xa_data_wr = '0;
  logic        wa_ready = 1'b0;

  logic        rdy1, rv1, wv1, ovf1, rdy3, rv3, wv3, ovf3;
  logic [15:0] rd1, wa1, wd1, rd3, wa3, wd3;
  logic [2:0]  lvl1, lvl3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sif_fifo #(.AW(16), .DW(16), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_wr_ready(rdy1),
    .xa_data_rd(rd1), .xa_rd_valid(rv1), .wa_wr_s(wv1), .wa_addr(wa1),
    .wa_data_wr(wd1), .wa_ready(wa_ready), .wr_overflow(ovf1), .fifo_level(lvl1)
  );

  sif_fifo #(.AW(16), .DW(16), .DEPTH(DEPTH), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_b(rst_b), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_wr_ready(rdy3),
    .xa_data_rd(rd3), .xa_rd_valid(rv3), .wa_wr_s(wv3), .wa_addr(wa3),
    .wa_data_wr(wd3), .wa_ready(wa_ready), .wr_overflow(ovf3), .fifo_level(lvl3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] scr(input logic [15:0] a);
    return {a[15:9], a[8] ^ a[4], a[7] ^ a[5], a[6:0]};
  endfunction

  // ------------------------------------------------------------------ model
  typedef struct packed { logic [15:0] a; logic [15:0] d; } word_t;
  word_t       q[$];
  logic        m_ovf = 1'b0;
  logic [15:0] last_a = '0, last_d = '0;
  logic        hv[$];
  logic [15:0] hd[$];

  function automatic logic [16:0] exp_rd(input int lat);
    int idx = hv.size() - lat;
    if (idx < 0) return '0;
    return {hv[idx], hd[idx]};
  endfunction

  always @(posedge clk) begin
    logic [16:0] e1, e3;
    if (!rst_b) begin
      q.delete(); hv.delete(); hd.delete();
      m_ovf = 1'b0; last_a = '0; last_d = '0;
    end else begin
      logic acc;
      acc = (q.size() < DEPTH);
      if (xa_wr_s && !acc) m_ovf = 1'b1;
      if (q.size() > 0 && wa_ready) void'(q.pop_front());
      if (xa_wr_s && acc) q.push_back('{a: xa_addr, d: xa_data_wr});
      if (q.size() > 0) begin last_a = q[0].a; last_d = q[0].d; end
      hv.push_back(xa_rd_s);
      hd.push_back(xa_rd_s ? scr(xa_addr) : 16'h0);
      if (hv.size() > 8) begin void'(hv.pop_front()); void'(hd.pop_front()); end
    end
    #1;
    e1 = exp_rd(1);
    e3 = exp_rd(3);
    chk("m_wa_wr_s1",  32'(wv1),  32'(q.size() > 0));
    chk("m_wa_addr1",  32'(wa1),  32'(last_a));
    chk("m_wa_data1",  32'(wd1),  32'(last_d));
    chk("m_level1",    32'(lvl1), 32'(q.size()));
    chk("m_wr_ready1", 32'(rdy1), 32'(q.size() < DEPTH));
    chk("m_ovf1",      32'(ovf1), 32'(m_ovf));
    chk("m_wa_wr_s3",  32'(wv3),  32'(q.size() > 0));
    chk("m_wa_data3",  32'(wd3),  32'(last_d));
    chk("m_wa_addr3",  32'(wa3),  32'(last_a));
    chk("m_level3",    32'(lvl3), 32'(q.size()));
    chk("m_ovf3",      32'(ovf3), 32'(m_ovf));
    chk("m_rd1",       32'({rv1, rd1}), 32'(e1));
    chk("m_rd3",       32'({rv3, rd3}), 32'(e3));
  end

  // -------------------------------------------------------------- stimulus
  task automatic idle();
    xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_addr = '0; xa_data_wr = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wa_wr_s"}, 32'({wv1, wv3}), 32'(0));
    chk({tag, "_rd_valid"}, 32'({rv1, rv3}), 32'(0));
    chk({tag, "_rd_data"}, 32'({rd1, rd3}), 32'(0));
    chk({tag, "_level"}, 32'({lvl1, lvl3}), 32'(0));
    chk({tag, "_wr_ready"}, 32'({rdy1, rdy3}), 32'(2'b11));
    chk({tag, "_ovf"}, 32'({ovf1, ovf3}), 32'(0));
  endtask

  logic [15:0] rd_a [3];
  logic [15:0] rd_e [3];

  initial begin
    int pw, pr, pk;
    rd_a[0] = 16'h05de; rd_a[1] = 16'h0463; rd_a[2] = 16'h1305;
    rd_e[0] = 16'h04de; rd_e[1] = 16'h04e3; rd_e[2] = 16'h1305;

    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      xa_wr_s = 1'($urandom); xa_rd_s = 1'($urandom);
      xa_addr = 16'($urandom); xa_data_wr = 16'($urandom); wa_ready = 1'($urandom);
    end
    @(posedge clk); #2;
    chk_reset_outputs("reset");
    @(negedge clk); idle(); wa_ready = 1'b1; rst_b = 1'b1;

    // Back-to-back reads; RD_LAT=1 and RD_LAT=3 instances side by side.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      idle();
      if (k < 3) begin xa_rd_s = 1'b1; xa_addr = rd_a[k]; end
      @(posedge clk); #2;
      chk("lit_rd1", 32'({rv1, rd1}), (k < 3) ? 32'({1'b1, rd_e[k]}) : 32'(0));
      chk("lit_rd3", 32'({rv3, rd3}), (k >= 2 && k < 5) ? 32'({1'b1, rd_e[k-2]}) : 32'(0));
    end

    // Single write with the sink ready.
    @(negedge clk); xa_wr_s = 1'b1; xa_addr = 16'h1234; xa_data_wr = 16'habcd; wa_ready = 1'b1;
    @(posedge clk); #2;
    chk("lit_single_out", 32'({wv1, wa1}), 32'({1'b1, 16'h1234}));
    chk("lit_single_data", 32'(wd1), 32'h0000abcd);
    @(negedge clk); idle();
    @(posedge clk); #2;
    chk("lit_single_drained", 32'({wv1, lvl1}), 32'(0));

    // Backpressure: five writes into a stalled sink, fifth dropped.
    @(negedge clk); wa_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      xa_wr_s = 1'b1; xa_addr = 16'(16'h0100 + i); xa_data_wr = 16'(i);
      @(posedge clk); #2;
      if (i == 4) chk("lit_full", 32'({rdy1, lvl1}), 32'({1'b0, 3'd4}));
    end
    chk("lit_dropped", 32'({ovf1, wd1}), 32'({1'b1, 16'h0001}));
    @(negedge clk); idle(); wa_ready = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      @(posedge clk); #2;
      if (j <= 4) chk("lit_drain", 32'({wv1, wd1}), 32'({1'b1, 16'(j)}));
      else        chk("lit_drain_end", 32'({wv1, ovf1}), 32'({1'b0, 1'b1}));
    end

    // Streaming: one push per cycle with the sink always ready.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      xa_wr_s = 1'b1; xa_addr = 16'(16'h2000 + i); xa_data_wr = 16'(16'h5a00 + i);
      @(posedge clk); #2;
      chk("lit_stream_lvl", 32'({lvl1, wd1}), 32'({3'd1, 16'(16'h5a00 + i)}));
    end
    // Sink stalls one cycle mid-stream.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wa_ready = (i != 2);
      xa_wr_s = 1'b1; xa_addr = 16'(16'h3000 + i); xa_data_wr = 16'(16'h6b00 + i);
    end
    @(negedge clk); idle(); wa_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Randomised traffic in phases of varying pressure.
    for (int ph = 0; ph < 6; ph++) begin
      pw = $urandom_range(10, 100); pr = $urandom_range(0, 100); pk = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        xa_wr_s    = ($urandom_range(0, 99) < pw);
        xa_rd_s    = ($urandom_range(0, 99) < pr);
        xa_addr    = 16'($urandom);
        xa_data_wr = 16'($urandom);
        wa_ready   = ($urandom_range(0, 99) < pk);
      end
    end

    // Reset mid-operation: 3 words buffered, 2 reads in flight on the LAT=3 copy.
    @(negedge clk); idle(); wa_ready = 1'b1;
    repeat (6) @(negedge clk);
    wa_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xa_wr_s = 1'b1; xa_addr = 16'(16'h4000 + i); xa_data_wr = 16'(16'h7c00 + i);
      @(negedge clk);
    end
    xa_wr_s = 1'b0;
    for (int i = 0; i < 2; i++) begin
      xa_rd_s = 1'b1; xa_addr = 16'(16'h01f0 + i);
      @(negedge clk);
    end
    idle();
    chk("lit_pre_rst_lvl", 32'(lvl1), 32'd3);
    rst_b = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_b = 1'b1; wa_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #2;
      chk("lit_post_rst", 32'({wv1, wv3, rv1, rv3}), 32'(0));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sif_fifo.md
Name: sif_fifo

Overview:
- Parametrised successor of the small training interface.
- Write requests (addr+data) are buffered in a DEPTH-entry FIFO and presented downstream with a valid/ready handshake instead of a fixed 1-cycle pass-through.
- Read requests return the bit-scrambled address after a configurable pipeline latency, with an explicit valid strobe.
- Sits between the training master (xa_*) and the write sink (wa_*).

Parameters:
- AW, 16, address width; must be >= 9.
- DW, 16, data width; read data is the scrambled address zero-extended or truncated to DW.
- DEPTH, 4, total write capacity in words, including the output register; power of 2, >= 2.
- RD_LAT, 1, read latency in clocks; range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- xa_wr_s  in  1  write request.
- xa_rd_s  in  1  read request.
- xa_addr  in  AW  address, shared by reads and writes.
- xa_data_wr  in  DW  write data.
- xa_wr_ready  out  1  write can be accepted; equals level < DEPTH.
- xa_data_rd  out  DW  read data.
- xa_rd_valid  out  1  xa_data_rd is valid this cycle.
- wa_wr_s  out  1  downstream write valid.
- wa_addr  out  AW  downstream address.
- wa_data_wr  out  DW  downstream data.
- wa_ready  in  1  downstream accepts the word this cycle.
- wr_overflow  out  1  sticky flag: a write was dropped.
- fifo_level  out  $clog2(DEPTH+1)  words held, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0 except xa_wr_ready, which is 1.
  - FIFO is emptied, read pipeline is flushed, wr_overflow is cleared.
  - Reset mid-operation discards all buffered words and in-flight reads; there is no wa_wr_s pulse on release.
- Push: xa_wr_s && xa_wr_ready stores {xa_addr, xa_data_wr}.
- Dropped write: xa_wr_s && !xa_wr_ready discards the word and sets wr_overflow; it stays set until reset.
- xa_wr_ready is a function of registered level only. There is no combinational path from wa_ready, so a full FIFO cannot accept a push even when a pop happens in the same cycle.
- Output stage:
  - wa_wr_s, wa_addr and wa_data_wr are registered; the output register holds the FIFO head.
  - A push into an empty FIFO shows wa_wr_s=1 on the next cycle, giving 1-cycle latency as in the previous generation.
  - Pop occurs on wa_wr_s && wa_ready; the next word, if any, appears the following cycle with no bubble.
  - While wa_wr_s=1 && !wa_ready, wa_addr and wa_data_wr are held stable.
  - When wa_wr_s=0, wa_addr and wa_data_wr hold their last value (0 after reset).
- Ordering is strict FIFO.
- Simultaneous push and pop: level is unchanged, and a word written to an empty-but-draining FIFO follows without a gap.
- fifo_level is updated on the clock edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Read scramble: S(a) = {a[AW-1:9], a[8]^a[4], a[7]^a[5], a[6:0]}.
- Read pipeline:
  - xa_rd_s in cycle N gives xa_rd_valid=1 and xa_data_rd=S(xa_addr) in cycle N+RD_LAT.
  - The pipeline is fully pipelined: back-to-back reads return back-to-back.
  - xa_data_rd = 0 whenever xa_rd_valid = 0.
- Read and write in the same cycle are both honoured, using the same xa_addr; the two paths are independent and reads never stall.

Decomposition:
- Package sif_pkg:
  - default constants SIF_AW=16, SIF_DW=16;
  - function sif_scramble(addr);
  - localparam for the level width.
- One sub-module, sif_wr_fifo: parametrised synchronous FIFO with registered head output and valid/ready pop, instantiated once for the write path.
- The read pipeline is a shift register in the top level.

Test Plan:
- Reset: hold rst_b=0 and toggle inputs -> wa_wr_s=0, xa_rd_valid=0, xa_data_rd=0, fifo_level=0, xa_wr_ready=1, wr_overflow=0.
- Reads with RD_LAT=1, then RD_LAT=3: back-to-back xa_addr 05de, 0463, 1305 -> xa_data_rd 04de, 04e3, 1305 on consecutive cycles, 1 (resp. 3) cycles later, with xa_rd_valid high for exactly 3 cycles.
- Single write, wa_ready=1: addr 1234, data abcd -> next cycle wa_wr_s=1, wa_addr=1234, wa_data_wr=abcd; the cycle after, wa_wr_s=0 and fifo_level=0.
- Backpressure, DEPTH=4, wa_ready=0: five writes with data 0001..0005 -> xa_wr_ready drops after the 4th, 0005 is dropped, wr_overflow=1. Then raise wa_ready -> 0001..0004 are output on 4 consecutive cycles and wr_overflow remains 1.
- Streaming: wa_ready=1 with a continuous push every cycle -> fifo_level stays 1 and one word is output per cycle in order. Toggling wa_ready 1-0-1 -> output is held stable while wa_ready=0, with no loss or duplication.
- Reset mid-operation: with 3 words buffered and 2 reads in flight, assert rst_b=0 -> all outputs return to reset values immediately, and nothing stale appears after release.
